// File: rtl/rand_pkg.sv
// Shared constants and types for the random byte packer.
package rand_pkg;

    localparam int unsigned BYTE_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 4;

    typedef logic [BYTE_W_DEF-1:0] byte_t;

    // Von Neumann pair tracking: waiting for first bit, or holding it.
    typedef enum logic {
        PAIR_EMPTY = 1'b0,
        PAIR_HALF  = 1'b1
    } pair_state_t;

endpackage

// File: rtl/rand_fifo.sv
// Single-clock synchronous FIFO holding packed bytes.
// A push on a full FIFO is taken only when a pop happens on the same edge.
module rand_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Next-state: qualify push/pop, advance pointers, track occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        level_d = level_q + LW'(do_push) - LW'(do_pop);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/rand_byte_pack.sv
// Serial random bit to byte packer with output FIFO.
// Optional von Neumann debiaser in front of the packer: RAND_BYTE_PACK_DEBIAS_EN.
// Note: rst_n is active-high despite its name (1 = reset).
module rand_byte_pack
    import rand_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned BYTE_W = BYTE_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    output logic [BYTE_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int unsigned CW = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

    logic              pack_valid_c;
    logic              pack_bit_c;
    logic [BYTE_W-1:0] sr_q, sr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              overflow_q, overflow_d;
    logic              push_c;
    logic [BYTE_W-1:0] push_data_c;
    logic              pop_c;
    logic              fifo_full;
    logic              fifo_empty;

`ifdef RAND_BYTE_PACK_DEBIAS_EN
    pair_state_t pair_q;
    logic        a_q;
    logic        emit_valid_q;
    logic        emit_bit_q;

    // Debiaser FSM: pair up accepted bits, emit the first bit of unequal pairs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pair_q       <= PAIR_EMPTY;
            a_q          <= 1'b0;
            emit_valid_q <= 1'b0;
            emit_bit_q   <= 1'b0;
        end else begin
            emit_valid_q <= 1'b0;
            if (bit_valid) begin
                case (pair_q)
                    PAIR_EMPTY: begin
                        a_q    <= bit_in;
                        pair_q <= PAIR_HALF;
                    end
                    PAIR_HALF: begin
                        pair_q <= PAIR_EMPTY;
                        if (a_q != bit_in) begin
                            emit_valid_q <= 1'b1;
                            emit_bit_q   <= a_q;
                        end
                    end
                    default: pair_q <= PAIR_EMPTY;
                endcase
            end
        end
    end

    assign pack_valid_c = emit_valid_q;
    assign pack_bit_c   = emit_bit_q;
`else
    assign pack_valid_c = bit_valid;
    assign pack_bit_c   = bit_in;
`endif

    assign pop_c = out_valid && out_ready;

    // Packer next-state: MSB-first shift, wrap counter, push and sticky overflow.
    always_comb begin
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        push_c      = 1'b0;
        push_data_c = {sr_q[BYTE_W-2:0], pack_bit_c};
        overflow_d  = overflow_q;
        if (pack_valid_c) begin
            sr_d = {sr_q[BYTE_W-2:0], pack_bit_c};
            if (cnt_q == CW'(BYTE_W - 1)) begin
                cnt_d  = '0;
                push_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (push_c && fifo_full && !pop_c) begin
            overflow_d = 1'b1;
        end
    end

    // Packer and overflow registers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sr_q       <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    rand_fifo #(
        .DEPTH (DEPTH),
        .W     (BYTE_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst_n),
        .push      (push_c),
        .push_data (push_data_c),
        .pop       (pop_c),
        .rd_data   (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fill_level)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;

endmodule
